// File: rtl/audio_pkg.sv
// audio_pkg: shared helpers for the audio PWM output path.
// Saturating left shift, offset-binary conversion and midscale constants.
package audio_pkg;

   // Result of a saturating shift: clamped value plus overflow flag.
   typedef struct packed {
      logic signed [31:0] value;
      logic               clipped;
   } sat_t;

   localparam int unsigned DEF_PWM_W    = 8;
   localparam int unsigned DEF_MIDSCALE = 1 << (DEF_PWM_W - 1);

   // Midscale code 2^(w-1) for a w-bit offset-binary value.
   function automatic logic [31:0] midscale(input int unsigned w);
      return 32'd1 << (w - 1);
   endfunction

   // Two's complement to offset binary: flip the sign bit, keep w bits.
   function automatic logic [31:0] offset_bin(
      input logic signed [31:0] x,
      input int unsigned        w
   );
      logic [31:0] mask;
      mask = (32'd1 << w) - 32'd1;
      return (x ^ midscale(w)) & mask;
   endfunction

   // Left shift with saturation to a signed w-bit range.
   // value must already fit w bits; w + shift must stay within 64.
   function automatic sat_t sat_shl(
      input logic signed [31:0] value,
      input int unsigned        shift,
      input int unsigned        w
   );
      logic signed [63:0] wide;
      logic signed [63:0] hi;
      logic signed [63:0] lo;
      sat_t               r;
      wide      = 64'(value) <<< shift;
      hi        = (64'sd1 <<< (w - 1)) - 64'sd1;
      lo        = -(64'sd1 <<< (w - 1));
      r.value   = 32'(wide);
      r.clipped = 1'b0;
      if (wide > hi) begin
         r.value   = 32'(hi);
         r.clipped = 1'b1;
      end else if (wide < lo) begin
         r.value   = 32'(lo);
         r.clipped = 1'b1;
      end
      return r;
   endfunction

endpackage

// File: rtl/audio_pwm_out_pwm_gen.sv
// pwm_gen: free-running PWM counter with wrap pulse.
// The output bit is a registered compare, one cycle behind the counter.
module pwm_gen
   import audio_pkg::*;
#(
   parameter int unsigned PWM_W = DEF_PWM_W
) (
   input  logic             clk_in,
   input  logic             rst_in,
   input  logic [PWM_W-1:0] level_in,
   output logic             pwm_out,
   output logic             wrap_out
);

   logic [PWM_W-1:0] cnt_q;
   logic [PWM_W-1:0] cnt_d;
   logic             pwm_q;
   logic             pwm_d;

   // Next counter value and duty compare against the active level.
   always_comb begin
      cnt_d = cnt_q + PWM_W'(1);
      pwm_d = (cnt_q < level_in);
   end

   // Counter and output bit registers.
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         cnt_q <= '0;
         pwm_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         pwm_q <= pwm_d;
      end
   end

   assign wrap_out = (cnt_q == '1);
   assign pwm_out  = pwm_q;

endmodule

// File: rtl/audio_pwm_out.sv
// audio_pwm_out: gain, volume and soft-mute stage feeding the speaker PWM.
// Samples are double-buffered so the duty only changes at period wraps.
module audio_pwm_out
   import audio_pkg::*;
#(
   parameter int unsigned IN_W     = 16,
   parameter int unsigned PWM_W    = 8,
   parameter int unsigned GAIN_W   = 4,
   parameter int unsigned VOL_W    = 3,
   parameter int unsigned RAMP_DIV = 256
) (
   input  logic                    clk_in,
   input  logic                    rst_in,
   input  logic                    ready_in,
   input  logic signed [IN_W-1:0]  sample_in,
   input  logic [GAIN_W-1:0]       gain_in,
   input  logic [VOL_W-1:0]        vol_in,
   input  logic                    mute_in,
   input  logic                    clear_in,
   output logic                    pwm_out,
   output logic [PWM_W-1:0]        level_out,
   output logic                    period_out,
   output logic                    clip_out,
   output logic                    overrun_out,
   output logic                    muted_out
);

   localparam int unsigned RATT_W = $clog2(PWM_W + 1);
   localparam int unsigned RCNT_W =
      (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;

   localparam logic [PWM_W-1:0]  MID =
      PWM_W'(midscale(PWM_W));
   localparam logic [RATT_W-1:0] RATT_MAX  = RATT_W'(PWM_W);
   localparam logic [RCNT_W-1:0] RCNT_LAST = RCNT_W'(RAMP_DIV - 1);

   // Stage 1: saturated sample and the volume shift that travels with it.
   logic signed [IN_W-1:0]  s1_q;
   logic signed [IN_W-1:0]  s1_d;
   logic                    s1_vld_q;
   logic                    s1_vld_d;
   logic [VOL_W-1:0]        vsh_q;
   logic [VOL_W-1:0]        vsh_d;
   sat_t                    sat;

   // Stage 2: pending sample waiting for the next period wrap.
   logic signed [PWM_W-1:0] s1_top;
   logic signed [PWM_W-1:0] pend_q;
   logic signed [PWM_W-1:0] pend_d;
   logic                    fresh_q;
   logic                    fresh_d;

   // Active duty, soft-mute ramp and sticky status.
   logic signed [PWM_W-1:0] att;
   logic [PWM_W-1:0]        active_q;
   logic [PWM_W-1:0]        active_d;
   logic [RATT_W-1:0]       ratt_q;
   logic [RATT_W-1:0]       ratt_d;
   logic [RCNT_W-1:0]       rcnt_q;
   logic [RCNT_W-1:0]       rcnt_d;
   logic                    clip_q;
   logic                    clip_d;
   logic                    ovr_q;
   logic                    ovr_d;
   logic                    ovr_set;
   logic                    wrap;

   // Stage 1: saturating gain shift; volume is latched with the sample.
   always_comb begin
      sat      = sat_shl(32'(sample_in), 32'(gain_in), IN_W);
      s1_vld_d = ready_in;
      s1_d     = s1_q;
      vsh_d    = vsh_q;
      if (ready_in) begin
         s1_d  = IN_W'(sat.value);
         vsh_d = ~vol_in;
      end
   end

   // Stage 2: take the top bits, apply volume, mark the buffer fresh.
   // A write landing on the wrap cycle keeps fresh set for the next period.
   always_comb begin
      s1_top  = s1_q[IN_W-1 -: PWM_W];
      pend_d  = pend_q;
      fresh_d = fresh_q;
      ovr_set = 1'b0;
      if (wrap) begin
         fresh_d = 1'b0;
      end
      if (s1_vld_q) begin
         pend_d  = s1_top >>> vsh_q;
         fresh_d = 1'b1;
         ovr_set = fresh_q && !wrap;
      end
   end

   // Wrap: load the attenuated pending sample as the new duty.
   always_comb begin
      att      = pend_q >>> ratt_q;
      active_d = active_q;
      if (wrap) begin
         if (ratt_q == RATT_MAX) begin
            active_d = MID;
         end else begin
            active_d = PWM_W'(offset_bin(32'(att), PWM_W));
         end
      end
   end

   // Soft-mute ramp: one attenuation step every RAMP_DIV periods.
   always_comb begin
      ratt_d = ratt_q;
      rcnt_d = rcnt_q;
      if (wrap) begin
         if (rcnt_q == RCNT_LAST) begin
            rcnt_d = '0;
            if (mute_in && (ratt_q < RATT_MAX)) begin
               ratt_d = ratt_q + RATT_W'(1);
            end else if (!mute_in && (ratt_q != '0)) begin
               ratt_d = ratt_q - RATT_W'(1);
            end
         end else begin
            rcnt_d = rcnt_q + RCNT_W'(1);
         end
      end
   end

   // Sticky flags; a clear wins over a set in the same cycle.
   always_comb begin
      clip_d = clip_q || (ready_in && sat.clipped);
      ovr_d  = ovr_q || ovr_set;
      if (clear_in) begin
         clip_d = 1'b0;
         ovr_d  = 1'b0;
      end
   end

   // State registers; reset leaves the output muted at midscale.
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         s1_q     <= '0;
         s1_vld_q <= 1'b0;
         vsh_q    <= '0;
         pend_q   <= '0;
         fresh_q  <= 1'b0;
         active_q <= MID;
         ratt_q   <= RATT_MAX;
         rcnt_q   <= '0;
         clip_q   <= 1'b0;
         ovr_q    <= 1'b0;
      end else begin
         s1_q     <= s1_d;
         s1_vld_q <= s1_vld_d;
         vsh_q    <= vsh_d;
         pend_q   <= pend_d;
         fresh_q  <= fresh_d;
         active_q <= active_d;
         ratt_q   <= ratt_d;
         rcnt_q   <= rcnt_d;
         clip_q   <= clip_d;
         ovr_q    <= ovr_d;
      end
   end

   pwm_gen #(
      .PWM_W (PWM_W)
   ) u_pwm (
      .clk_in   (clk_in),
      .rst_in   (rst_in),
      .level_in (active_q),
      .pwm_out  (pwm_out),
      .wrap_out (wrap)
   );

   assign level_out   = active_q;
   assign period_out  = wrap;
   assign clip_out    = clip_q;
   assign overrun_out = ovr_q;
   assign muted_out   = (ratt_q == RATT_MAX);

endmodule

// File: doc/audio_pwm_out.md
# audio_pwm_out

Parametrised audio output stage that replaces the fixed switch-driven shift, volume shifter and 8-bit PWM currently in front of the speaker. It accepts signed samples on a one-cycle `ready_in` strobe. Each sample gets a saturating gain shift, volume attenuation and a soft mute ramp, and is re-timed so the PWM duty only changes at period boundaries. It sits between the FIR/ANC output and the `aud_pwm` pin driver.

## Interface
- `IN_W`, 16: sample width (signed, two's complement).
- `PWM_W`, 8: PWM resolution; period = 2^PWM_W clocks.
- `GAIN_W`, 4: gain shift select width; left shift 0..2^GAIN_W-1.
- `VOL_W`, 3: volume select width.
- `RAMP_DIV`, 256: PWM periods per soft-mute ramp step (>=1).
- `clk_in` in 1: system clock (100 MHz).
- `rst_in` in 1: reset, asynchronous, active-high.
- `ready_in` in 1: one-cycle strobe; `sample_in` valid.
- `sample_in` in IN_W: signed sample.
- `gain_in` in GAIN_W: left-shift amount, sampled with `ready_in`.
- `vol_in` in VOL_W: volume; right shift = (2^VOL_W-1) - `vol_in`, sampled with `ready_in`.
- `mute_in` in 1: level; high ramps to silence, low ramps up.
- `clear_in` in 1: clears the sticky `clip_out` and `overrun_out` flags.
- `pwm_out` out 1: registered PWM bit.
- `level_out` out PWM_W: active duty (offset binary).
- `period_out` out 1: one-cycle pulse on the PWM wrap cycle.
- `clip_out` out 1: sticky; gain saturation occurred.
- `overrun_out` out 1: sticky; a staged sample was overwritten before it was used.
- `muted_out` out 1: high when ramp attenuation = PWM_W.

## Operation
- Stage 1 (on `ready_in`): compute `s1 = sat_IN_W(sample_in <<< gain_in)`.
  - Overflow saturates to +2^(IN_W-1)-1 or -2^(IN_W-1) and sets `clip_out`.
  - A value that exactly fits is not a clip.
- Stage 2: `s2 = s1[IN_W-1 -: PWM_W] >>> vol_shift`, arithmetic. The result is written to the `pend` register and `pend_fresh` is set.
  - If `pend_fresh` is already set when stage 2 writes, set `overrun_out`. The newest sample wins.
- PWM counter `cnt` (PWM_W bits) free-runs. The wrap cycle is `cnt == 2^PWM_W-1`. On the wrap cycle:
  - `active <= (ratt == PWM_W) ? midscale : {~x[PWM_W-1], x[PWM_W-2:0]}`, where `x = pend >>> ratt`. Midscale = 2^(PWM_W-1).
  - `pend_fresh` clears. If stage 2 writes `pend` on this same cycle, the new value is not used, `pend_fresh` stays set, and no overrun is flagged.
  - With no new sample, `pend` is reused.
- Soft mute: `ratt` is 0..PWM_W and `rcnt` is 0..RAMP_DIV-1.
  - On each wrap cycle, `rcnt` increments. When `rcnt == RAMP_DIV-1` it returns to 0 and `ratt` steps:
    - +1 if `mute_in` is high and `ratt < PWM_W`;
    - -1 if `mute_in` is low and `ratt > 0`.
  - Toggling `mute_in` mid-ramp reverses direction at the next step; `rcnt` is not reset.
- `pwm_out <= (cnt < active)` every cycle.
- `clear_in` has priority over a same-cycle set: the flag ends up cleared.

## Timing
- Reset values: `cnt=0`, `active=midscale`, `level_out=midscale`, `pend=0`, `pend_fresh=0`, `ratt=PWM_W` (power-up muted), `rcnt=0`, `pwm_out=0`, `period_out=0`, `clip_out=0`, `overrun_out=0`, `muted_out=1`.
- `ready_in` at cycle t: stage 1 registered at t+1, `pend` at t+2, `clip_out` asserted at t+1.
- `pend` to `active`: at the first wrap cycle at or after t+3. Worst case is t+2+2^PWM_W.
- `pwm_out` lags `cnt`/`active` by 1 cycle.
- `ready_in` on consecutive cycles is legal; every sample flows through both stages.
- Full ramp 0 to PWM_W takes PWM_W·RAMP_DIV·2^PWM_W clocks; 8·256·256 ≈ 5.2 ms at 100 MHz.
- Reset mid-operation clears all state immediately, even mid-period. The next period starts from `cnt=0`, muted.

## Structure
- Package `audio_pkg`:
  - function `offset_bin(signed, w)`;
  - function `sat_shl(value, shift, w)` returning {sat_value, clipped};
  - localparam-style constants for midscale.
- Sub-module `pwm_gen`: counter, wrap pulse and registered compare; parameter PWM_W; ports `clk_in`, `rst_in`, `level_in`, `pwm_out`, `wrap_out`.
- The top holds the sample stages, `pend`/`active` double buffer, ramp and flags.

## Test plan
- Reset, then `mute_in=0`:
  - `muted_out=1` and `level_out=0x80` until the first step at 256 periods;
  - `ratt` reaches 0 after 8·256 periods;
  - `pwm_out` duty during mute = 128/256.
- Unmuted, `vol_in=7`, `gain_in=0`, `sample_in=0x4000`:
  - `s2=0x40`, `level_out=0xC0` at the next wrap;
  - `pwm_out` high 192 of 256 cycles.
- `sample_in=0x0100`, `gain_in=8` gives 0x7FFF and `clip_out=1`. `gain_in=7` gives 0x8000 negative-overflow? No: 0x0100<<7 = 0x8000, which overflows positive, so it saturates to 0x7FFF and clips. `sample_in=0xFF00`, `gain_in=7` gives 0x8000 exactly, no clip.
- Two `ready_in` strobes within one period (0x2000, then 0x6000):
  - `overrun_out=1`;
  - next `level_out` = offset of 0x60 = 0xE0.
- `vol_in=4`, `sample_in=0x8000`, `gain_in=0`: `s2=0x80>>>3=0xF0`, `level_out=0x70`.
- Assert `rst_in` mid-period with `active=0xE0`: `pwm_out=0`, `level_out=0x80`, `muted_out=1` on the same edge. Check that `clear_in` clears sticky flags.
